// File: rtl/word_serializer_pkg.sv
// Shared encodings for the word serializer: FSM state values and the
// bit-order selector used by the LSB_FIRST parameter.
package word_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam bit BIT_MSB_FIRST = 1'b0;
    localparam bit BIT_LSB_FIRST = 1'b1;

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial front end for the sequence detectors: a shifter plus a
// one-word holding buffer so consecutive words stream with no idle bit between.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int W         = 4,
    parameter bit LSB_FIRST = BIT_MSB_FIRST
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic         pause,
    output logic         x,
    output logic         x_valid,
    output logic         busy,
    output logic         word_done
);

    localparam int             CW       = $clog2(W);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(W - 1);

    state_e         state_q, state_d;
    logic [W-1:0]   shift_q, shift_d;
    logic [W-1:0]   hold_q, hold_d;
    logic           holdFull_q, holdFull_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           xfer;
    logic           lastBit;
    logic           headBit;
    logic [W-1:0]   shifted;

    assign headBit = (LSB_FIRST == BIT_LSB_FIRST) ? shift_q[0] : shift_q[W-1];
    assign shifted = (LSB_FIRST == BIT_LSB_FIRST) ? {1'b0, shift_q[W-1:1]}
                                                  : {shift_q[W-2:0], 1'b0};

    // din_ready depends only on registered state, never on din_valid.
    assign din_ready = !holdFull_q;
    assign xfer      = din_valid & !holdFull_q;
    assign lastBit   = (cnt_q == '0);
    assign x_valid   = (state_q == SHIFT);
    assign x         = x_valid & headBit;
    assign word_done = x_valid & lastBit & !pause;
    assign busy      = x_valid | holdFull_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        holdFull_d = holdFull_q;
        cnt_d      = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    shift_d = din;
                    cnt_d   = CNT_LOAD;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!pause && lastBit) begin
                    // Retiring edge: refill from hold, else bypass din, else stop.
                    if (holdFull_q) begin
                        shift_d    = hold_q;
                        cnt_d      = CNT_LOAD;
                        holdFull_d = 1'b0;
                    end else if (xfer) begin
                        shift_d = din;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        shift_d = '0;
                        state_d = IDLE;
                    end
                end else begin
                    if (!pause) begin
                        shift_d = shifted;
                        cnt_d   = cnt_q - CW'(1);
                    end
                    if (xfer) begin
                        hold_d     = din;
                        holdFull_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            hold_q     <= '0;
            holdFull_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            holdFull_q <= holdFull_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench for word_serializer: expected bits are queued on each
// accepted transfer and popped as the serial stream emerges, feeding a 1101 detector model.
module tb_word_serializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         pause;
    logic         x;
    logic         x_valid;
    logic         busy;
    logic         word_done;

    logic [W-1:0] dinL;
    logic         dinValidL;
    logic         dinReadyL;
    logic         pauseL;
    logic         xL;
    logic         xValidL;
    logic         busyL;
    logic         wordDoneL;

    int checkCount = 0;
    int passCount  = 0;
    int bitsSeen   = 0;

    logic [1:0] sb[$];
    logic [3:0] hist;
    int         bitIdx;
    int         foundAt[$];

    always #5 clk = ~clk;

    word_serializer #(.W(W), .LSB_FIRST(1'b0)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .pause(pause), .x(x), .x_valid(x_valid),
        .busy(busy), .word_done(word_done)
    );

    word_serializer #(.W(W), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .reset(reset), .din(dinL), .din_valid(dinValidL),
        .din_ready(dinReadyL), .pause(pauseL), .x(xL), .x_valid(xValidL),
        .busy(busyL), .word_done(wordDoneL)
    );

    // Each accepted word becomes W expected {last, bit} entries, MSB first.
    always @(posedge clk) begin
        if (!reset && din_valid && din_ready) begin
            for (int i = 0; i < W; i++)
                sb.push_back({(i == W - 1), din[W-1-i]});
        end
    end

    // Overlapping 1101 detector model consuming each retired serial bit.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist   <= '0;
            bitIdx <= 0;
            foundAt.delete();
        end else if (x_valid && !pause) begin
            hist   <= {hist[2:0], x};
            bitIdx <= bitIdx + 1;
            if ({hist[2:0], x} == 4'b1101)
                foundAt.push_back(bitIdx + 1);
        end
    end

    // A pending expected bit must be on x every cycle, so any gap is caught here.
    always @(negedge clk) begin
        if (!reset && (x_valid || sb.size() != 0)) begin
            logic [1:0] e;
            checkCount++;
            if (!x_valid) begin
                $display("[TB] FAIL stream_gap: x_valid=0 required 1 (%0d bits pending)", sb.size());
            end else if (sb.size() == 0) begin
                $display("[TB] FAIL unexpected_bit: x=%0b with no word pending", x);
            end else if (pause) begin
                if (word_done !== 1'b0)
                    $display("[TB] FAIL paused_word_done: got %0b required 0", word_done);
                else
                    passCount++;
            end else begin
                e = sb.pop_front();
                bitsSeen++;
                if (x !== e[0] || word_done !== e[1])
                    $display("[TB] FAIL serial_bit: x=%0b word_done=%0b required x=%0b word_done=%0b",
                             x, word_done, e[0], e[1]);
                else
                    passCount++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        sb.delete();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        checkCount++;
        if ({x, x_valid, busy, word_done, din_ready} !== 5'b00001)
            $display("[TB] FAIL reset_outputs: x,xv,busy,wd,rdy=%05b required 00001",
                     {x, x_valid, busy, word_done, din_ready});
        else
            passCount++;
        checkCount++;
        if ({xL, xValidL, busyL, wordDoneL, dinReadyL} !== 5'b00001)
            $display("[TB] FAIL reset_outputs_lsb: got %05b required 00001",
                     {xL, xValidL, busyL, wordDoneL, dinReadyL});
        else
            passCount++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int n;
        din = 4'b1101; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 20) begin tick(); n++; end
        checkCount++;
        if (sb.size() != 0) $display("[TB] FAIL single_timeout: %0d bits left, required 0", sb.size());
        else passCount++;
        checkCount++;
        if (x_valid !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL single_idle: x_valid=%0b busy=%0b required 0 0", x_valid, busy);
        else
            passCount++;
    endtask

    task automatic test_back_to_back();
        int n;
        doReset();
        din = 4'b1101; din_valid = 1'b1;
        tick();
        din = 4'b1011;
        tick();
        din_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 30) begin tick(); n++; end
        checkCount++;
        if (sb.size() != 0) $display("[TB] FAIL b2b_timeout: %0d bits left, required 0", sb.size());
        else passCount++;
        checkCount++;
        if (foundAt.size() != 2)
            $display("[TB] FAIL b2b_found_count: got %0d required 2", foundAt.size());
        else if (foundAt[0] != 4 || foundAt[1] != 7)
            $display("[TB] FAIL b2b_found_pos: got %0d,%0d required 4,7", foundAt[0], foundAt[1]);
        else
            passCount++;
    endtask

    task automatic test_three_words();
        int n;
        int stalls;
        int startBits;
        doReset();
        startBits = bitsSeen;
        din = 4'b1110; din_valid = 1'b1;
        tick();
        din = 4'b0011;
        tick();
        checkCount++;
        if (din_ready !== 1'b0 || busy !== 1'b1)
            $display("[TB] FAIL three_full: din_ready=%0b busy=%0b required 0 1", din_ready, busy);
        else
            passCount++;
        din = 4'b1010;
        stalls = 0;
        while (!din_ready && stalls < 20) begin tick(); stalls++; end
        checkCount++;
        if (stalls != 3)
            $display("[TB] FAIL three_stall: din_ready rose after %0d cycles, required 3", stalls);
        else
            passCount++;
        tick();
        din_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 40) begin tick(); n++; end
        checkCount++;
        if (bitsSeen - startBits != 12 || sb.size() != 0)
            $display("[TB] FAIL three_bits: got %0d bits required 12", bitsSeen - startBits);
        else
            passCount++;
    endtask

    task automatic test_pause();
        int n;
        doReset();
        din = 4'b1001; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick();
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkCount++;
            if (x !== 1'b0 || x_valid !== 1'b1 || word_done !== 1'b0)
                $display("[TB] FAIL pause_hold%0d: x=%0b xv=%0b wd=%0b required 0 1 0",
                         i, x, x_valid, word_done);
            else
                passCount++;
        end
        pause = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 20) begin tick(); n++; end
        checkCount++;
        if (sb.size() != 0 || x_valid !== 1'b0)
            $display("[TB] FAIL pause_drain: left=%0d x_valid=%0b required 0 0", sb.size(), x_valid);
        else
            passCount++;
    endtask

    task automatic test_reset_mid();
        int n;
        doReset();
        din = 4'b1111; din_valid = 1'b1;
        tick();
        din = 4'b1100;
        tick();
        din_valid = 1'b0;
        tick();
        reset = 1'b1;
        sb.delete();
        tick();
        checkCount++;
        if (x_valid !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b1)
            $display("[TB] FAIL midreset: xv=%0b busy=%0b rdy=%0b required 0 0 1",
                     x_valid, busy, din_ready);
        else
            passCount++;
        reset = 1'b0;
        tick();
        checkCount++;
        if (x_valid !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL midreset_release: xv=%0b busy=%0b required 0 0", x_valid, busy);
        else
            passCount++;
        din = 4'b0110; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 20) begin tick(); n++; end
        checkCount++;
        if (sb.size() != 0) $display("[TB] FAIL midreset_drain: %0d bits left, required 0", sb.size());
        else passCount++;
    endtask

    task automatic test_lsb_first();
        logic [W-1:0] word;
        word = 4'b1011;
        dinL = word; dinValidL = 1'b1;
        tick();
        dinValidL = 1'b0;
        for (int i = 0; i < W; i++) begin
            checkCount++;
            if (xL !== word[i] || xValidL !== 1'b1 || wordDoneL !== (i == W - 1))
                $display("[TB] FAIL lsb_bit%0d: x=%0b xv=%0b wd=%0b required %0b 1 %0b",
                         i, xL, xValidL, wordDoneL, word[i], (i == W - 1));
            else
                passCount++;
            tick();
        end
        checkCount++;
        if (xValidL !== 1'b0 || busyL !== 1'b0)
            $display("[TB] FAIL lsb_idle: xv=%0b busy=%0b required 0 0", xValidL, busyL);
        else
            passCount++;
    endtask

    initial begin
        reset = 1'b1;
        din = '0; din_valid = 1'b0; pause = 1'b0;
        dinL = '0; dinValidL = 1'b0; pauseL = 1'b0;
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_three_words();
        test_pause();
        test_reset_mid();
        test_lsb_first();
        tick();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
